// File: rtl/axil_playback.sv
// Playback buffer: the host fills a BRAM over AXI4-Lite writes and the fabric streams it out.
// Define AXIL_PLAYBACK_READBACK_EN to add an AXI read path into the same BRAM.
module axil_playback #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 11
) (
  input  logic                   fpga_clk,
  input  logic                   rst,
  input  logic [ADDR_SIZE+1:0]   S_AXI_AWADDR,
  input  logic [2:0]             S_AXI_AWPROT,
  input  logic                   S_AXI_AWVALID,
  output logic                   S_AXI_AWREADY,
  input  logic [WORD_SIZE-1:0]   S_AXI_WDATA,
  input  logic [WORD_SIZE/8-1:0] S_AXI_WSTRB,
  input  logic                   S_AXI_WVALID,
  output logic                   S_AXI_WREADY,
  output logic [1:0]             S_AXI_BRESP,
  output logic                   S_AXI_BVALID,
  input  logic                   S_AXI_BREADY,
  input  logic [ADDR_SIZE+1:0]   S_AXI_ARADDR,
  input  logic [2:0]             S_AXI_ARPROT,
  input  logic                   S_AXI_ARVALID,
  output logic                   S_AXI_ARREADY,
  output logic [WORD_SIZE-1:0]   S_AXI_RDATA,
  output logic [1:0]             S_AXI_RRESP,
  output logic                   S_AXI_RVALID,
  input  logic                   S_AXI_RREADY,
  input  logic [31:0]            configuration,
  input  logic [ADDR_SIZE-1:0]   length,
  input  logic                   trigger,
  input  logic                   dout_en,
  output logic [WORD_SIZE-1:0]   dout,
  output logic                   dout_valid,
  output logic                   busy
);

  localparam int NUM_BYTES = WORD_SIZE / 8;

  typedef enum logic [1:0] {IDLE, ARMED, PLAY} state_t;

  logic [WORD_SIZE-1:0] mem [2**ADDR_SIZE];

  logic                 live;
  logic                 aw_full;
  logic [ADDR_SIZE-1:0] aw_idx;
  logic                 w_full;
  logic [WORD_SIZE-1:0] w_data;
  logic [NUM_BYTES-1:0] w_strb;
  logic                 bvalid;
  logic                 commit;

  // Ready flags stay low through reset and the first clock after it.
  assign S_AXI_AWREADY = live & ~aw_full;
  assign S_AXI_WREADY  = live & ~w_full;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign commit        = aw_full & w_full & ~bvalid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge fpga_clk or posedge rst) begin
    if (rst) begin
      live    <= 1'b0;
      aw_full <= 1'b0;
      aw_idx  <= '0;
      w_full  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
    end else begin
      live <= 1'b1;
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
      end else if (bvalid && S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_full <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[ADDR_SIZE+1:2];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
    end
  end

  // NOTE: the BRAM array has no reset so it maps onto block RAM; contents survive rst.
  always_ff @(posedge fpga_clk) begin
    if (commit) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (w_strb[b]) mem[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  logic [3:0]           cfg_r;
  logic [3:0]           cfg_rr;
  logic                 trigger_r;
  logic                 arm;
  logic                 trig_edge;
  logic                 step;
  state_t               state;
  state_t               state_next;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [ADDR_SIZE-1:0] rd_addr_next;
  logic                 rd_en;

  assign arm       = cfg_r[0] & ~cfg_rr[0];
  assign trig_edge = trigger & ~trigger_r;
  assign step      = dout_en | cfg_r[3];
  assign busy      = (state != IDLE);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next   = state;
    rd_addr_next = rd_addr;
    rd_en        = 1'b0;
    case (state)
      IDLE: ;
      ARMED: begin
        if (trig_edge || cfg_r[2]) begin
          state_next   = PLAY;
          rd_addr_next = '0;
        end
      end
      PLAY: begin
        if (step) begin
          rd_en = 1'b1;
          if (rd_addr == length) begin
            if (cfg_r[1]) rd_addr_next = '0;
            else          state_next   = IDLE;
          end else begin
            rd_addr_next = rd_addr + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Re-arming restarts from any state; a read issued this cycle still completes.
    if (arm) begin
      state_next   = ARMED;
      rd_addr_next = '0;
    end
  end

  always_ff @(posedge fpga_clk or posedge rst) begin
    if (rst) begin
      cfg_r      <= '0;
      cfg_rr     <= '0;
      trigger_r  <= 1'b0;
      state      <= IDLE;
      rd_addr    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      cfg_r      <= configuration[3:0];
      cfg_rr     <= cfg_r;
      trigger_r  <= trigger;
      state      <= state_next;
      rd_addr    <= rd_addr_next;
      dout_valid <= rd_en;
      if (rd_en) dout <= mem[rd_addr];
    end
  end

  logic unused_in;

`ifdef AXIL_PLAYBACK_READBACK_EN
  logic                 rvalid;
  logic [WORD_SIZE-1:0] rdata;

  assign S_AXI_ARREADY = live & ~rvalid;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = 2'b00;

  always_ff @(posedge fpga_clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      rvalid <= 1'b1;
      rdata  <= mem[S_AXI_ARADDR[ADDR_SIZE+1:2]];
    end else if (rvalid && S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end

  assign unused_in = ^{S_AXI_AWPROT, S_AXI_AWADDR[1:0], S_AXI_ARPROT, S_AXI_ARADDR[1:0],
                       configuration[31:4]};
`else
  assign S_AXI_ARREADY = 1'b0;
  assign S_AXI_RVALID  = 1'b0;
  assign S_AXI_RDATA   = '0;
  assign S_AXI_RRESP   = 2'b00;

  assign unused_in = ^{S_AXI_AWPROT, S_AXI_AWADDR[1:0], S_AXI_ARPROT, S_AXI_ARADDR,
                       S_AXI_ARVALID, S_AXI_RREADY, configuration[31:4]};
`endif

endmodule
